// File: rtl/hex_scan_display.sv
// hex_scan_display: time-multiplexed hex seven-segment driver.
// A double-buffered value register feeds NUM_DIGITS scanned digits. Frames
// (one full scan) are the only points where the displayed value may change.
// The display can optionally blank leading zeros and blink as a whole.
//
// state      | meaning
// -----------+------------------------------------------------------------
// presc      | cycles spent on the current digit, 0..SCAN_DIV-1
// idx        | digit currently being scanned, 0..NUM_DIGITS-1
// frame_cnt  | completed frames within the current blink half-period
// phase      | blink phase, 1 = segments blanked when blink_en is set
// pending    | value captured by load, waiting for the frame boundary
module hex_scan_display #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clock,
    input  logic                    reset_l,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] shown,
    output logic                    update_pending,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0]        presc;
    logic [IDX_W-1:0]        idx;
    logic [FRM_W-1:0]        frame_cnt;
    logic                    phase;
    logic [4*NUM_DIGITS-1:0] pending;

    logic                    pre_wrap;
    logic                    boundary;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    zero_above;
    logic [3:0]              cur_nib;
    logic                    cur_lz;
    logic [NUM_DIGITS-1:0]   cur_onehot;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h67;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Frame boundary decode; frame_done comes straight from the counters.
    always_comb begin
        pre_wrap = (presc == PRE_LAST);
        boundary = pre_wrap && (idx == IDX_LAST);
    end

    assign frame_done = boundary;

    // Digit i is blank-eligible when it and every more significant nibble are zero.
    always_comb begin
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above  = zero_above && (shown[4*i +: 4] == 4'h0);
            lz_blank[i] = (i != 0) && zero_above;
        end
    end

    // Select the nibble, blank flag and enable for the digit being scanned.
    always_comb begin
        cur_nib    = 4'h0;
        cur_lz     = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib       = shown[4*i +: 4];
                cur_lz        = lz_blank[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    // Scan counters: prescaler per digit, digit index per prescaler wrap.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            presc <= '0;
            idx   <= '0;
        end else if (pre_wrap) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Blink timing: count frames and flip the phase every BLINK_FRAMES frames.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (boundary) begin
            if (frame_cnt == FRM_LAST) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Double buffer: loads park in pending and only reach shown at a frame boundary.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            pending        <= '0;
            shown          <= '0;
            update_pending <= 1'b0;
        end else if (boundary) begin
            // A load landing on the boundary itself goes straight to the display.
            if (load) begin
                shown <= value;
            end else if (update_pending) begin
                shown <= pending;
            end
            update_pending <= 1'b0;
        end else if (load) begin
            pending        <= value;
            update_pending <= 1'b1;
        end
    end

    // Registered digit drive; seg and dig_en update on the same edge.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            seg    <= '0;
            dig_en <= '0;
        end else begin
            dig_en <= cur_onehot;
            if ((blink_en && phase) || (blank_lz && cur_lz)) begin
                seg <= '0;
            end else begin
                seg <= hex_to_seg(cur_nib);
            end
        end
    end

endmodule
